// File: rtl/multi_edge_detector.sv
// -----------------------------------------------------------------------------
// multi_edge_detector
//
// Multi-channel edge detector with input synchronisation and glitch filtering.
// Each channel runs independently:
//   signal_in -> SYNC_STAGES-flop synchroniser -> run-length filter (lvl/run)
//   -> registered edge pulse qualified by the per-channel mode
//   -> sticky "edge seen" flag and saturating edge counter.
//
// Parameters
//   CHANNELS    number of independent channels (1..32)
//   SYNC_STAGES synchroniser depth per channel (1..4)
//   FILTER_LEN  consecutive samples of a new level needed to accept it (1..255)
//   CNT_WIDTH   width of each per-channel edge counter (1..16)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous, active-high reset of all state
//   signal_in   asynchronous channel inputs
//   mode        per channel [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
//   sticky_clr  per channel level clear of the sticky flag
//   cnt_clr     per channel level clear of the edge counter
//   edge_out    one-cycle pulse per qualifying edge (registered)
//   level_out   filtered, synchronised level
//   sticky      latched "edge seen" flags
//   count       saturating edge counts, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   any_edge    OR of edge_out
// -----------------------------------------------------------------------------
module multi_edge_detector #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           signal_in,
    input  logic [2*CHANNELS-1:0]         mode,
    input  logic [CHANNELS-1:0]           sticky_clr,
    input  logic [CHANNELS-1:0]           cnt_clr,
    output logic [CHANNELS-1:0]           edge_out,
    output logic [CHANNELS-1:0]           level_out,
    output logic [CHANNELS-1:0]           sticky,
    output logic [CHANNELS*CNT_WIDTH-1:0] count,
    output logic                          any_edge
);

    localparam int                    RUN_W    = $clog2(FILTER_LEN + 1);
    localparam logic [RUN_W-1:0]      RUN_LAST = RUN_W'(FILTER_LEN - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [RUN_W-1:0]       r_run;
        logic                   r_lvl;
        logic                   r_edge;
        logic                   r_sticky;
        logic [CNT_WIDTH-1:0]   r_cnt;

        logic w_sync;
        logic w_flip;
        logic w_event;

        assign w_sync = r_sync[SYNC_STAGES-1];

        // The accepted level flips on the FILTER_LEN-th consecutive sample that
        // disagrees with it; run only counts the samples before that one.
        assign w_flip = (w_sync != r_lvl) && (r_run == RUN_LAST);

        // After a flip the new level equals w_sync: 1 means a rising edge
        // (mode bit 0), 0 a falling edge (mode bit 1).
        assign w_event = w_flip && (w_sync ? mode[2*g] : mode[2*g+1]);

        // Synchroniser: bit 0 captures the raw input, the MSB feeds the filter.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= (r_sync << 1) | SYNC_STAGES'(signal_in[g]);
            end
        end

        // Filter: run-length qualification of the synchronised level.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_run <= '0;
                r_lvl <= 1'b0;
            end else if (w_sync == r_lvl) begin
                r_run <= '0;
            end else if (w_flip) begin
                r_run <= '0;
                r_lvl <= ~r_lvl;
            end else begin
                r_run <= r_run + 1'b1;
            end
        end

        // Edge pulse, sticky flag and counter all update on the flip clock.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_edge   <= 1'b0;
                r_sticky <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_edge <= w_event;

                // A new edge takes priority over a simultaneous clear.
                if (w_event) begin
                    r_sticky <= 1'b1;
                end else if (sticky_clr[g]) begin
                    r_sticky <= 1'b0;
                end

                // Clear with a coincident edge leaves that edge counted.
                if (cnt_clr[g]) begin
                    r_cnt <= w_event ? CNT_ONE : '0;
                end else if (w_event) begin
                    r_cnt <= sat_inc(r_cnt);
                end
            end
        end

        assign edge_out[g]                          = r_edge;
        assign level_out[g]                         = r_lvl;
        assign sticky[g]                            = r_sticky;
        assign count[g*CNT_WIDTH +: CNT_WIDTH]      = r_cnt;
    end

    assign any_edge = |edge_out;

endmodule

// File: tb/tb_multi_edge_detector.sv
// -----------------------------------------------------------------------------
// Testbench for multi_edge_detector.
// dut0: defaults (4 ch, 2 sync, FILTER_LEN 1, CNT_WIDTH 8)
// dut1: 4 ch, 2 sync, FILTER_LEN 3, CNT_WIDTH 2
// The reference model keeps a history of raw input samples per edge and
// accepts a new level when the last FILTER_LEN synchronised samples all
// disagree with the current level.
// -----------------------------------------------------------------------------
module tb_multi_edge_detector;

    localparam int S = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] sig  [2];
    logic [7:0] md   [2];
    logic [3:0] sclr [2];
    logic [3:0] cclr [2];

    logic [3:0]  edge_o [2];
    logic [3:0]  lvl_o  [2];
    logic [3:0]  stk_o  [2];
    logic        any_o  [2];
    logic [31:0] cnt0;
    logic [7:0]  cnt1;

    int checks = 0;
    int errors = 0;

    multi_edge_detector #(
        .CHANNELS(4), .SYNC_STAGES(2), .FILTER_LEN(1), .CNT_WIDTH(8)
    ) dut0 (
        .clk(clk), .rst(rst), .signal_in(sig[0]), .mode(md[0]),
        .sticky_clr(sclr[0]), .cnt_clr(cclr[0]), .edge_out(edge_o[0]),
        .level_out(lvl_o[0]), .sticky(stk_o[0]), .count(cnt0), .any_edge(any_o[0])
    );

    multi_edge_detector #(
        .CHANNELS(4), .SYNC_STAGES(2), .FILTER_LEN(3), .CNT_WIDTH(2)
    ) dut1 (
        .clk(clk), .rst(rst), .signal_in(sig[1]), .mode(md[1]),
        .sticky_clr(sclr[1]), .cnt_clr(cclr[1]), .edge_out(edge_o[1]),
        .level_out(lvl_o[1]), .sticky(stk_o[1]), .count(cnt1), .any_edge(any_o[1])
    );

    // ---------------- reference model ----------------
    int         F    [2] = '{1, 3};
    int         CMAX [2] = '{255, 3};
    logic [3:0] m_hist [2][8];   // m_hist[d][k]: raw input captured k edges ago
    logic [3:0] m_lvl  [2];
    logic [3:0] m_edge [2];
    logic [3:0] m_stk  [2];
    int         m_cnt  [2][4];

    function automatic void model_reset(int d);
        for (int k = 0; k < 8; k++) m_hist[d][k] = '0;
        m_lvl[d]  = '0;
        m_edge[d] = '0;
        m_stk[d]  = '0;
        for (int c = 0; c < 4; c++) m_cnt[d][c] = 0;
    endfunction

    function automatic void model_step(int d);
        logic flip;
        logic ev;
        for (int k = 7; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
        m_hist[d][0] = sig[d];
        for (int c = 0; c < 4; c++) begin
            flip = 1'b1;
            for (int j = 0; j < F[d]; j++)
                if (m_hist[d][S+j][c] == m_lvl[d][c]) flip = 1'b0;
            ev = 1'b0;
            if (flip) begin
                m_lvl[d][c] = ~m_lvl[d][c];
                ev = m_lvl[d][c] ? md[d][2*c] : md[d][2*c+1];
            end
            m_edge[d][c] = ev;
            if (ev) m_stk[d][c] = 1'b1;
            else if (sclr[d][c]) m_stk[d][c] = 1'b0;
            if (cclr[d][c]) m_cnt[d][c] = ev ? 1 : 0;
            else if (ev && m_cnt[d][c] < CMAX[d]) m_cnt[d][c]++;
        end
    endfunction

    function automatic int act_cnt(int d, int c);
        if (d == 0) return int'(cnt0[c*8 +: 8]);
        return int'(cnt1[c*2 +: 2]);
    endfunction

    // One clock: advance the model at the edge, return 1 time unit later.
    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) model_reset(d);
            else     model_step(d);
        end
        #1;
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            sig[d] = '0; md[d] = '0; sclr[d] = '0; cclr[d] = '0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) model_reset(d);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({edge_o[d], lvl_o[d], stk_o[d], any_o[d]} !== 13'h0) begin
                errors++;
                $display("FAIL reset_out dut%0d: got %b/%b/%b/%b want 0", d,
                         edge_o[d], lvl_o[d], stk_o[d], any_o[d]);
            end
        end
        checks++;
        if (cnt0 !== 32'h0 || cnt1 !== 8'h0) begin
            errors++;
            $display("FAIL reset_cnt: got %h/%h want 0", cnt0, cnt1);
        end
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_rise_defaults();
        int pulses;
        md[0] = 8'b00_00_00_01;
        sig[0][0] = 1'b1;
        tick();                     // edge N captures the new level
        tick();                     // N+1
        checks++;
        if (edge_o[0][0] !== 1'b0) begin
            errors++; $display("FAIL rise_early: got %b want 0", edge_o[0][0]);
        end
        tick();                     // N+2
        checks++;
        if ({edge_o[0][0], lvl_o[0][0], stk_o[0][0], any_o[0]} !== 4'b1111) begin
            errors++;
            $display("FAIL rise_pulse: got e%b l%b s%b a%b want 1111",
                     edge_o[0][0], lvl_o[0][0], stk_o[0][0], any_o[0]);
        end
        checks++;
        if (cnt0[7:0] !== 8'd1) begin
            errors++; $display("FAIL rise_count: got %0d want 1", cnt0[7:0]);
        end
        tick();
        checks++;
        if (edge_o[0][0] !== 1'b0) begin
            errors++; $display("FAIL rise_width: got %b want 0", edge_o[0][0]);
        end
        sig[0][0] = 1'b0;
        pulses = 0;
        repeat (6) begin
            tick();
            pulses += int'(edge_o[0][0]);
        end
        checks++;
        if (pulses != 0 || lvl_o[0][0] !== 1'b0) begin
            errors++;
            $display("FAIL rise_nofall: got pulses %0d lvl %b want 0 0", pulses, lvl_o[0][0]);
        end
    endtask

    task automatic test_modes();
        int  np [4];
        int  tp [4][2];
        logic lvl3_seen;
        md[0] = 8'b00_11_10_01;
        for (int c = 0; c < 4; c++) np[c] = 0;
        lvl3_seen = 1'b0;
        sig[0][3:1] = 3'b111;
        for (int t = 0; t < 12; t++) begin
            if (t == 4) sig[0][3:1] = 3'b000;
            tick();
            for (int c = 1; c < 4; c++) begin
                if (edge_o[0][c]) begin
                    if (np[c] < 2) tp[c][np[c]] = t;
                    np[c]++;
                end
            end
            if (lvl_o[0][3]) lvl3_seen = 1'b1;
        end
        checks++;
        if (np[1] != 1 || np[2] != 2 || np[3] != 0) begin
            errors++;
            $display("FAIL mode_pulses: got %0d/%0d/%0d want 1/2/0", np[1], np[2], np[3]);
        end
        checks++;
        if (np[2] == 2 && np[1] == 1 && (tp[2][1] - tp[2][0] != 4 || tp[1][0] != tp[2][1])) begin
            errors++;
            $display("FAIL mode_spacing: got rise %0d fall %0d ch1 %0d want spacing 4",
                     tp[2][0], tp[2][1], tp[1][0]);
        end
        checks++;
        if (act_cnt(0, 1) != 1 || act_cnt(0, 2) != 2 || act_cnt(0, 3) != 0) begin
            errors++;
            $display("FAIL mode_counts: got %0d/%0d/%0d want 1/2/0",
                     act_cnt(0, 1), act_cnt(0, 2), act_cnt(0, 3));
        end
        checks++;
        if (!lvl3_seen || stk_o[0][3] !== 1'b0) begin
            errors++;
            $display("FAIL mode_disabled: got lvl_seen %b sticky %b want 1 0", lvl3_seen, stk_o[0][3]);
        end
    endtask

    task automatic test_filter();
        int pulses;
        logic hi_seen;
        md[1] = 8'b00_00_00_11;
        pulses = 0; hi_seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            sig[1][0] = (t < 2);
            tick();
            pulses += int'(edge_o[1][0]);
            if (lvl_o[1][0]) hi_seen = 1'b1;
        end
        checks++;
        if (pulses != 0 || hi_seen) begin
            errors++;
            $display("FAIL filter_glitch: got pulses %0d lvl_seen %b want 0 0", pulses, hi_seen);
        end
        pulses = 0;
        for (int t = 0; t < 12; t++) begin
            sig[1][0] = (t < 3);
            tick();
            pulses += int'(edge_o[1][0]);
        end
        checks++;
        if (pulses != 2 || act_cnt(1, 0) != 2 || lvl_o[1][0] !== 1'b0) begin
            errors++;
            $display("FAIL filter_pulse: got pulses %0d count %0d lvl %b want 2 2 0",
                     pulses, act_cnt(1, 0), lvl_o[1][0]);
        end
    endtask

    // One rise/fall on dut1 ch1, optionally with clears on the flip clock.
    task automatic pulse_d1c1(input logic do_cclr, input logic do_sclr,
                              output logic e, output int c, output logic s);
        sig[1][1] = 1'b1;
        repeat (4) tick();
        cclr[1][1] = do_cclr;
        sclr[1][1] = do_sclr;
        tick();
        e = edge_o[1][1];
        c = act_cnt(1, 1);
        s = stk_o[1][1];
        cclr[1][1] = 1'b0;
        sclr[1][1] = 1'b0;
        sig[1][1]  = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_saturate();
        logic e, s;
        int   c;
        md[1] = 8'b00_00_01_00;
        for (int i = 1; i <= 5; i++) begin
            pulse_d1c1(1'b0, 1'b0, e, c, s);
            checks++;
            if (e !== 1'b1 || c != ((i < 3) ? i : 3)) begin
                errors++;
                $display("FAIL sat_rise%0d: got edge %b count %0d want 1 %0d",
                         i, e, c, (i < 3) ? i : 3);
            end
        end
        pulse_d1c1(1'b1, 1'b0, e, c, s);
        checks++;
        if (e !== 1'b1 || c != 1) begin
            errors++; $display("FAIL sat_clr_edge: got edge %b count %0d want 1 1", e, c);
        end
        pulse_d1c1(1'b0, 1'b1, e, c, s);
        checks++;
        if (s !== 1'b1) begin
            errors++; $display("FAIL sticky_set_wins: got %b want 1", s);
        end
        sclr[1][1] = 1'b1;
        tick();
        sclr[1][1] = 1'b0;
        checks++;
        if (stk_o[1][1] !== 1'b0) begin
            errors++; $display("FAIL sticky_clear: got %b want 0", stk_o[1][1]);
        end
    endtask

    task automatic test_reset_release();
        md[0] = 8'b00_00_00_01;
        rst = 1'b1;
        sig[0][0] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) model_reset(d);
        tick(); tick();
        rst = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            checks++;
            if (edge_o[0][0] !== ((t == 3) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL release_edge t%0d: got %b want %b", t, edge_o[0][0], t == 3);
            end
        end
        sig[0][0] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_mid_filter_reset();
        md[1] = 8'b11_11_00_00;
        sig[1][3] = 1'b1;
        repeat (6) tick();
        sig[1][2] = 1'b1;
        repeat (4) tick();          // ch2 run now at 2 of 3
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) model_reset(d);
        checks++;
        if ({edge_o[1], lvl_o[1], stk_o[1], any_o[1], cnt1} !== 21'h0) begin
            errors++;
            $display("FAIL midrst_out: got l%b s%b c%h want 0", lvl_o[1], stk_o[1], cnt1);
        end
        tick();
        rst = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick();
            checks++;
            if (edge_o[1][3:2] !== ((t == 5) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL midrst_edge t%0d: got %b want %b", t, edge_o[1][3:2],
                         (t == 5) ? 2'b11 : 2'b00);
            end
        end
        sig[1] = '0;
        repeat (6) tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if (k % 50 == 0) begin
                md[0] = 8'($urandom);
                md[1] = 8'($urandom);
            end
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < 4; c++) begin
                    if ($urandom_range(3, 0) == 0) sig[d][c] = ~sig[d][c];
                    sclr[d][c] = ($urandom_range(15, 0) == 0);
                    cclr[d][c] = ($urandom_range(31, 0) == 0);
                end
            end
            if ($urandom_range(199, 0) == 0) begin
                rst = 1'b1;
                #1;
                for (int d = 0; d < 2; d++) model_reset(d);
                tick();
                rst = 1'b0;
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (edge_o[d] !== m_edge[d] || any_o[d] !== (|m_edge[d])) begin
                    errors++;
                    $display("FAIL rnd_edge dut%0d cyc %0d: got %b/%b want %b/%b", d, k,
                             edge_o[d], any_o[d], m_edge[d], |m_edge[d]);
                end
                checks++;
                if (lvl_o[d] !== m_lvl[d]) begin
                    errors++;
                    $display("FAIL rnd_level dut%0d cyc %0d: got %b want %b", d, k, lvl_o[d], m_lvl[d]);
                end
                checks++;
                if (stk_o[d] !== m_stk[d]) begin
                    errors++;
                    $display("FAIL rnd_sticky dut%0d cyc %0d: got %b want %b", d, k, stk_o[d], m_stk[d]);
                end
                for (int c = 0; c < 4; c++) begin
                    checks++;
                    if (act_cnt(d, c) != m_cnt[d][c]) begin
                        errors++;
                        $display("FAIL rnd_count dut%0d ch%0d cyc %0d: got %0d want %0d",
                                 d, c, k, act_cnt(d, c), m_cnt[d][c]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_rise_defaults();
        test_reset();
        test_modes();
        test_reset();
        test_filter();
        test_reset();
        test_saturate();
        test_reset();
        test_reset_release();
        test_reset();
        test_mid_filter_reset();
        test_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
